// File: rtl/jt10_adpcm_pkg.sv
// Shared definitions for the JT10 ADPCM-A control block: register map,
// slot geometry, update-FSM encoding and small helper functions.
package jt10_adpcm_pkg;

  // Number of ADPCM-A channels, which is also the number of pipeline slots
  localparam int NUM_SLOTS = 6;

  // CPU register map
  localparam logic [7:0] ADDR_KEY   = 8'h00;
  localparam logic [7:0] ADDR_ATL   = 8'h01;
  localparam logic [7:0] ADDR_LRACL = 8'h08;  // channels 0..5 at 0x08..0x0D

  // up_ch value meaning "no gain update in progress"
  localparam logic [2:0] UP_NONE = 3'd7;

  // Hold counter load: outputs stay valid for HOLD_LOAD+1 cen pulses,
  // i.e. one full slot rotation
  localparam logic [2:0] HOLD_LOAD = 3'(NUM_SLOTS - 1);

  // Gain-update delivery states
  typedef enum logic {
    UPD_IDLE = 1'b0,
    UPD_HOLD = 1'b1
  } upd_state_e;

  // Index of the lowest set bit, UP_NONE when no bit is set
  function automatic logic [2:0] lowest_set(input logic [5:0] v);
    logic [2:0] idx;
    idx = UP_NONE;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // One-position left rotation of a one-hot slot vector
  function automatic logic [5:0] rotl6(input logic [5:0] v);
    return {v[4:0], v[5]};
  endfunction

endpackage

// File: rtl/jt10_adpcm_upd.sv
// Gain (lracl) update sequencer. Each written channel is flagged pending;
// the lowest pending channel is presented on up_ch/lracl for one full slot
// rotation, then released. A rewrite of the channel being delivered keeps
// it pending so the fresh value is delivered afterwards.
module jt10_adpcm_upd
  import jt10_adpcm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [5:0]  set_pend,
  input  logic [47:0] lracl_flat,
  output logic [2:0]  up_ch,
  output logic [7:0]  lracl
);

  upd_state_e  state, state_nx;
  logic [5:0]  pending, pending_nx;
  logic [5:0]  sel_oh, sel_oh_nx;
  logic [5:0]  pend_clr;
  logic [2:0]  cnt, cnt_nx;
  logic [2:0]  up_ch_nx;
  logic [2:0]  pick;
  logic [7:0]  lracl_nx;
  logic        redo, redo_nx;
  logic        keep;

  // Next-state logic: pick, hold and release one channel's gain update
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nx  = state;
    cnt_nx    = cnt;
    sel_oh_nx = sel_oh;
    redo_nx   = redo;
    up_ch_nx  = up_ch;
    lracl_nx  = lracl;
    pend_clr  = '0;
    keep      = 1'b0;
    pick      = lowest_set(pending);

    unique case (state)
      UPD_IDLE: begin
        up_ch_nx = UP_NONE;
        if (cen && pending != '0) begin
          sel_oh_nx = 6'(1) << pick;
          up_ch_nx  = pick;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pick == 3'(i)) lracl_nx = lracl_flat[i*8 +: 8];
          end
          cnt_nx    = HOLD_LOAD;
          // a rewrite landing on the very edge we latch must still be served
          redo_nx   = |(set_pend & (6'(1) << pick));
          state_nx  = UPD_HOLD;
        end
      end
      UPD_HOLD: begin
        keep    = redo | (|(set_pend & sel_oh));
        redo_nx = keep;
        if (cen) begin
          if (cnt == '0) begin
            if (!keep) pend_clr = sel_oh;
            redo_nx  = 1'b0;
            up_ch_nx = UP_NONE;
            state_nx = UPD_IDLE;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end
      end
      default: state_nx = UPD_IDLE;
    endcase

    // a new write always wins over the end-of-delivery clear
    pending_nx = (pending & ~pend_clr) | set_pend;
  end

  // State register for the update sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UPD_IDLE;
      pending <= '0;
      sel_oh  <= '0;
      cnt     <= '0;
      redo    <= 1'b0;
      up_ch   <= UP_NONE;
      lracl   <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples the pre-edge values, independent of statement order.
      state   <= state_nx;
      pending <= pending_nx;
      sel_oh  <= sel_oh_nx;
      cnt     <= cnt_nx;
      redo    <= redo_nx;
      up_ch   <= up_ch_nx;
      lracl   <= lracl_nx;
    end
  end

endmodule

// File: rtl/jt10_adpcm_ctrl.sv
// JT10 ADPCM-A channel control: CPU register file, slot/round rotation,
// key-on/key-off tracking and the gain-update sequencer.
module jt10_adpcm_ctrl
  import jt10_adpcm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic [5:0] end_ch,
  output logic [5:0] cur_ch,
  output logic [5:0] en_ch,
  output logic       match,
  output logic [2:0] up_ch,
  output logic [7:0] lracl,
  output logic [5:0] atl,
  output logic [5:0] ch_on,
  output logic [5:0] keyon
);

  logic [7:0]  lracl_reg [NUM_SLOTS];
  logic [47:0] lracl_flat;
  logic [5:0]  kon, koff, set_pend;
  logic        atl_we;

  // Write decode: key control, total level and per-channel gain strobes
  always_comb begin
    kon      = '0;
    koff     = '0;
    set_pend = '0;
    atl_we   = wr && (addr == ADDR_ATL);
    if (wr && addr == ADDR_KEY) begin
      if (din[7]) koff = din[5:0];
      else        kon  = din[5:0];
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (wr && addr == ADDR_LRACL + 8'(i)) set_pend[i] = 1'b1;
    end
  end

  // Flatten the gain registers for the sequencer
  always_comb begin
    lracl_flat = '0;
    for (int i = 0; i < NUM_SLOTS; i++) lracl_flat[i*8 +: 8] = lracl_reg[i];
  end

  // Gain register file, written on any clk regardless of cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the gain array is only six bytes and must read as zero after
      // reset, so it is built from resettable flops rather than a RAM.
      for (int i = 0; i < NUM_SLOTS; i++) lracl_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (set_pend[i]) lracl_reg[i] <= din;
      end
    end
  end

  // Total level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      atl <= '0;
    else if (atl_we) atl <= din[5:0];
  end

  // Channel activity: key-off and end-of-sample clear, key-on sets and wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch_on <= '0;
    else        ch_on <= (ch_on & ~koff & ~end_ch) | kon;
  end

  // Key-on pulse: set by the write, dropped on the following cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keyon <= '0;
    else        keyon <= (cen ? 6'd0 : keyon) | kon;
  end

  // Slot rotation every cen; round advances when the last slot wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch <= 6'b000001;
      en_ch  <= 6'b000001;
    end else if (cen) begin
      cur_ch <= rotl6(cur_ch);
      if (cur_ch[5]) en_ch <= rotl6(en_ch);
    end
  end

  assign match = (cur_ch == en_ch) && ((ch_on & en_ch) != '0);

  jt10_adpcm_upd u_upd (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .set_pend   (set_pend),
    .lracl_flat (lracl_flat),
    .up_ch      (up_ch),
    .lracl      (lracl)
  );

endmodule

// File: tb/tb_jt10_adpcm_ctrl.sv
// Self-checking bench for jt10_adpcm_ctrl. A behavioural model tracks slot
// timing, channel state and the gain-update queue; started deliveries are
// pushed to a scoreboard that a separate monitor pops when up_ch leaves 7.
module tb_jt10_adpcm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, cen, wr;
  logic [7:0] addr, din;
  logic [5:0] end_ch;
  logic [5:0] cur_ch, en_ch, atl, ch_on, keyon;
  logic       match;
  logic [2:0] up_ch;
  logic [7:0] lracl;

  jt10_adpcm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .end_ch(end_ch), .cur_ch(cur_ch), .en_ch(en_ch), .match(match),
    .up_ch(up_ch), .lracl(lracl), .atl(atl), .ch_on(ch_on), .keyon(keyon)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int ch; logic [7:0] v; } upd_t;
  upd_t exp_q[$];

  int         cen_count;
  bit  [5:0]  chon_m, keyon_m, pend_m;
  logic [5:0] atl_m;
  logic [7:0] val_m [6];
  logic [7:0] lracl_m;
  bit         busy, rew;
  int         cur_p, remain;
  bit         mon_en = 1'b0;

  task automatic model_reset();
    cen_count = 0; chon_m = '0; keyon_m = '0; pend_m = '0; atl_m = '0;
    for (int i = 0; i < 6; i++) val_m[i] = '0;
    lracl_m = '0; busy = 0; rew = 0; cur_p = 0; remain = 0;
    exp_q.delete();
  endtask

  // One clock edge as seen by the model: delivery timing first (it uses
  // the state before this edge's write), then the write and end_ch.
  task automatic model_update(input bit c, input bit w, input logic [7:0] a,
                              input logic [7:0] d, input logic [5:0] e);
    bit [5:0] kon = '0, koff = '0;
    if (c) begin
      cen_count++;
      if (busy) begin
        remain--;
        if (remain == 0) begin
          busy = 0;
          if (!rew) pend_m[cur_p] = 1'b0;
        end
      end else if (pend_m != '0) begin
        cur_p = 0;
        while (!pend_m[cur_p]) cur_p++;
        busy = 1; remain = 6; rew = 0;
        lracl_m = val_m[cur_p];
        exp_q.push_back('{cur_p, val_m[cur_p]});
      end
    end
    if (w) begin
      if (a == 8'h00) begin
        if (d[7]) koff = d[5:0]; else kon = d[5:0];
      end else if (a == 8'h01) begin
        atl_m = d[5:0];
      end else if (a >= 8'h08 && a <= 8'h0D) begin
        val_m[a - 8'h08] = d;
        pend_m[a - 8'h08] = 1'b1;
        if (busy && int'(a - 8'h08) == cur_p) rew = 1;
      end
    end
    chon_m  = (chon_m & ~koff & ~e) | kon;
    keyon_m = (c ? 6'd0 : keyon_m) | kon;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit c, input bit w, input logic [7:0] a,
                      input logic [7:0] d, input logic [5:0] e);
    @(negedge clk);
    cen = c; wr = w; addr = a; din = d; end_ch = e;
    @(posedge clk);
    model_update(c, w, a, d, e);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d, 6'd0);
  endtask

  task automatic run_cens(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 8'h00, 8'h00, 6'd0);
      step(1'b0, 1'b0, 8'h00, 8'h00, 6'd0);
      step(1'b0, 1'b0, 8'h00, 8'h00, 6'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0; cen = 1'b0; wr = 1'b0; addr = '0; din = '0; end_ch = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cur_ch", 32'(cur_ch), 32'h01);
    check("rst_en_ch",  32'(en_ch),  32'h01);
    check("rst_up_ch",  32'(up_ch),  32'h7);
    check("rst_lracl",  32'(lracl),  32'h0);
    check("rst_atl",    32'(atl),    32'h0);
    check("rst_ch_on",  32'(ch_on),  32'h0);
    check("rst_keyon",  32'(keyon),  32'h0);
    check("rst_match",  32'(match),  32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  bit         in_del = 0;
  int         del_start;
  int         del_ch;
  logic [7:0] del_val;

  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      in_del = 0;
    end else begin
      int slot, round;
      slot  = cen_count % 6;
      round = (cen_count / 6) % 6;
      check("cur_ch", 32'(cur_ch), 32'(6'(1) << slot));
      check("en_ch",  32'(en_ch),  32'(6'(1) << round));
      check("match",  32'(match),  32'((slot == round) && chon_m[round]));
      check("ch_on",  32'(ch_on),  32'(chon_m));
      check("keyon",  32'(keyon),  32'(keyon_m));
      check("atl",    32'(atl),    32'(atl_m));
      check("lracl_level", 32'(lracl), 32'(lracl_m));
      if (!in_del && up_ch != 3'd7) begin
        if (exp_q.size() == 0) begin
          check("unexpected_update", 32'(up_ch), 32'h7);
        end else begin
          upd_t x;
          x = exp_q.pop_front();
          check("upd_ch",    32'(up_ch), 32'(x.ch));
          check("upd_lracl", 32'(lracl), 32'(x.v));
        end
        in_del = 1; del_start = cen_count; del_ch = int'(up_ch); del_val = lracl;
      end else if (in_del && up_ch != 3'd7) begin
        if (int'(up_ch) != del_ch || lracl !== del_val) begin
          check("upd_stable_ch",    32'(up_ch), 32'(del_ch));
          check("upd_stable_lracl", 32'(lracl), 32'(del_val));
        end
      end else if (in_del && up_ch == 3'd7) begin
        check("upd_hold_cens", 32'(cen_count - del_start), 32'd6);
        in_del = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b1; cen = 1'b0; wr = 1'b0; addr = '0; din = '0; end_ch = '0;
    model_reset();
    do_reset();

    // 36 idle cens: full round cycle with no active channel
    run_cens(36);
    check("en_ch_after_36", 32'(en_ch), 32'h01);

    // key-on channels 0 and 2
    wr_reg(8'h00, 8'h05);
    @(negedge clk);
    check("keyon_pulse", 32'(keyon), 32'h05);
    run_cens(40);

    // single gain update
    wr_reg(8'h09, 8'hC3);
    run_cens(10);

    // two updates in one cen period: channel 2 before channel 5
    wr_reg(8'h0D, 8'h11);
    wr_reg(8'h0A, 8'h22);
    run_cens(16);

    // rewrite during hold
    wr_reg(8'h0A, 8'h22);
    run_cens(3);
    wr_reg(8'h0A, 8'h33);
    run_cens(16);

    // end_ch and key-on in the same clk: key-on wins, key-off clears
    wr_reg(8'h00, 8'h80 | 8'h3F);
    step(1'b0, 1'b1, 8'h00, 8'h01, 6'b000001);
    @(negedge clk);
    check("kon_beats_end", 32'(ch_on[0]), 32'h1);
    wr_reg(8'h00, 8'h81);
    @(negedge clk);
    check("koff_clears", 32'(ch_on[0]), 32'h0);

    // total level uses the low six bits
    wr_reg(8'h01, 8'hFF);
    run_cens(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit         c, w;
      logic [7:0] a, d;
      logic [5:0] e;
      c = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       a = 8'h00;
        1:       a = 8'h01;
        2, 3:    a = 8'h08 + 8'($urandom_range(0, 5));
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom);
      e = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      step(c, w, a, d, e);
    end

    // reset during hold aborts the delivery; nothing is issued afterwards
    for (int i = 0; i < 200 && (busy || pend_m != '0); i++) run_cens(1);
    wr_reg(8'h0B, 8'h5A);
    run_cens(3);
    check("hold_before_reset", 32'(up_ch), 32'h3);
    do_reset();
    run_cens(12);
    check("no_update_after_reset", 32'(up_ch), 32'h7);

    // drain and final scoreboard state
    wr_reg(8'h0C, 8'hA5);
    for (int i = 0; i < 200 && (busy || pend_m != '0); i++) run_cens(1);
    run_cens(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("no_open_delivery", 32'(in_del), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt10_adpcm_ctrl.md
JT10_ADPCM_CTRL -- requirements
Module: jt10_adpcm_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cen, input, 1 bit: 666 kHz clock enable; all slot and round timing advances only when cen=1.
REQ-004 SHALL have ports wr, input, 1 bit; addr, input, 8 bits; din, input, 8 bits: CPU write strobe, address and data, sampled on any clk edge where wr=1, independent of cen.
REQ-005 SHALL have port end_ch, input, 6 bits: per-channel end-of-sample pulse from the decoder.
REQ-006 SHALL have port cur_ch, output, 6 bits: one-hot pipeline slot.
REQ-007 SHALL have port en_ch, output, 6 bits: one-hot channel owning the current round.
REQ-008 SHALL have port match, output, 1 bit: new-sample slot indicator.
REQ-009 SHALL have ports up_ch, output, 3 bits; lracl, output, 8 bits: gain-update channel index and value; up_ch=7 means no update.
REQ-010 SHALL have port atl, output, 6 bits: ADPCM total level.
REQ-011 SHALL have ports ch_on, output, 6 bits; keyon, output, 6 bits: channel-active flags and one-cen key-on pulses.

Function
REQ-012 Register map SHALL be: 0x00 key control (din[7]=1 means dump/key-off of channels in din[5:0], otherwise key-on); 0x01 atl=din[5:0]; 0x08..0x0D lracl for channels 0..5; all other addresses ignored.
REQ-013 cur_ch SHALL rotate left, {cur_ch[4:0],cur_ch[5]}, on every cen.
REQ-014 en_ch SHALL rotate left on the cen where cur_ch==6'b100000, giving a 36-cen full cycle.
REQ-015 match SHALL be combinational: 1 iff cur_ch==en_ch and (ch_on & en_ch)!=0.
REQ-016 A key-on write SHALL set ch_on[i] and set keyon[i] for each din[i]=1; keyon[i] SHALL clear on the next cen after it is set.
REQ-017 A key-off write or end_ch[i]=1 SHALL clear ch_on[i].
REQ-018 If key-on and end_ch hit the same channel in the same clk, key-on SHALL win.
REQ-019 A write to 0x08+n SHALL store the value in lracl_reg[n] and set pending[n].
REQ-020 Update FSM SHALL have states IDLE and HOLD.
REQ-021 In IDLE with pending!=0 on a cen, the FSM SHALL select the lowest pending index p, drive up_ch=p and lracl=lracl_reg[p], load a 3-bit hold counter with 5, and enter HOLD.
REQ-022 In HOLD the FSM SHALL keep up_ch and lracl stable and decrement the counter each cen, so the outputs are held exactly 6 cen (one full slot rotation).
REQ-023 When the HOLD counter reaches 0 on a cen, the FSM SHALL clear pending[p] and return to IDLE with up_ch=7.
REQ-024 If lracl_reg[p] is rewritten during HOLD, pending[p] SHALL stay set, lracl SHALL keep the latched value, and p SHALL be re-served later.
REQ-025 In IDLE, lracl SHALL hold its last value and up_ch SHALL be 7.
REQ-026 Writes to other channels during HOLD SHALL only set pending and SHALL NOT alter the current delivery.
REQ-027 A write with no cen pulse SHALL take effect in the registers immediately; timing-side effects SHALL wait for the next cen.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously set cur_ch=6'b000001, en_ch=6'b000001, up_ch=7, lracl=0, atl=0, ch_on=0, keyon=0, pending=0, all lracl_reg=0, and FSM=IDLE.
REQ-029 Reset during HOLD SHALL abort the delivery, and no update SHALL be issued after release until a new write.

Structure
REQ-030 The register addresses, the no-update code 7 and the slot count 6 SHALL be defined in the shared jt10 ADPCM package.
REQ-031 The update FSM SHALL be a sub-module, jt10_adpcm_upd, owning pending, the hold counter, up_ch and lracl; the top level holds the register file, slot counters and key logic.

Verification
REQ-032 Reset release followed by 36 cen SHALL show cur_ch cycling 6 times and en_ch returning to 000001, with match=0 throughout since ch_on=0.
REQ-033 Write 0x00=0x05 SHALL give ch_on=000101 and keyon=000101 for one cen; match SHALL then pulse in the slots of channels 0 and 2 only.
REQ-034 Write 0x09=0xC3 SHALL give up_ch=1 and lracl=0xC3 for exactly 6 cen, then up_ch=7 and pending=0.
REQ-035 Writes 0x0D=0x11 and 0x0A=0x22 in the same cen period SHALL serve channel 2 first, then channel 5, each for 6 cen.
REQ-036 Rewrite 0x0A=0x33 during the channel-2 HOLD SHALL finish the delivery with 0x22, then issue a second 6-cen delivery with 0x33.
REQ-037 end_ch=000001 in the same clk as key-on write 0x00=0x01 SHALL leave ch_on[0]=1; a later write 0x00=0x81 SHALL clear it.
